// File: rtl/rescale_line_buffer.sv
// Two-row sliding input window for the rescale engine. Source rows stream in
// over AXI-Stream; row k lands in slot k[0]. On a request for top row T the
// block fills until rows T and min(T+1,SRC_H-1) are resident, then serves
// the four bilinear neighbours for a column offset with one cycle of latency.
module rescale_line_buffer #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int PIX_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESETN,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic             S_AXIS_TLAST,
  input  logic [8:0]       row_to_wait,
  input  logic             skip,
  input  logic             in_stream_ready,
  output logic             buffer_done,
  input  logic [10:0]      neighbor_offset,
  output logic [PIX_W-1:0] neighbor0,
  output logic [PIX_W-1:0] neighbor1,
  output logic [PIX_W-1:0] neighbor2,
  output logic [PIX_W-1:0] neighbor3,
  output logic             ERROR
);

  localparam int          COL_AW  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam logic [9:0]  COL_MAX = 10'(SRC_W - 1);
  localparam logic [8:0]  ROW_MAX = 9'(SRC_H - 1);
  localparam logic [8:0]  ROW_END = 9'(SRC_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t r_state, w_state_d;

  // Row slots and stream position
  logic [PIX_W-1:0] r_mem [2][SRC_W];
  logic [9:0]       r_wr_col;
  logic [8:0]       r_wr_row;
  logic [8:0]       r_last_row;
  logic             r_last_vld;

  // Latched request
  logic             r_top_slot;
  logic [8:0]       r_need;

  // Registered outputs
  logic             r_tready;
  logic             r_done;
  logic             r_error;
  logic [PIX_W-1:0] r_nb0, r_nb1, r_nb2, r_nb3;

  // Stream-side decode
  logic             w_beat;
  logic             w_in_frame;
  logic             w_col_end;
  logic             w_wr;
  logic             w_close;
  logic             w_len_fault;
  logic             w_eof_fault;

  // Request-side decode
  logic [8:0]       w_req_need;
  logic             w_resident;
  logic             w_latch;
  logic             w_evict_err;

  // Neighbour addressing
  logic [9:0]       w_col_c;
  logic [9:0]       w_col_n;
  logic             w_unused_offset_msb;

  assign w_unused_offset_msb = neighbor_offset[10];

  assign w_beat      = S_AXIS_TVALID & r_tready;
  assign w_in_frame  = (r_wr_row < ROW_END);
  assign w_col_end   = (r_wr_col == COL_MAX);
  // A beat arriving with frame_start is dropped: the new frame wins.
  assign w_wr        = w_beat & w_in_frame & ~frame_start;
  assign w_close     = w_wr & (S_AXIS_TLAST | w_col_end);
  assign w_len_fault = w_wr & (S_AXIS_TLAST ^ w_col_end);
  // Beats past the last source row are swallowed and flagged.
  assign w_eof_fault = w_beat & ~w_in_frame;

  // Bottom row pairs with itself, so need saturates at the last row.
  assign w_req_need = (row_to_wait >= ROW_MAX) ? ROW_MAX : (row_to_wait + 9'd1);
  assign w_resident = r_last_vld && (r_last_row >= w_req_need);

  // Column offsets clamp to the row so the right neighbour repeats the edge.
  assign w_col_c = (neighbor_offset[9:0] > COL_MAX) ? COL_MAX : neighbor_offset[9:0];
  assign w_col_n = (w_col_c == COL_MAX) ? COL_MAX : (w_col_c + 10'd1);

  // Next-state logic for the request handshake
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_d   = r_state;
    w_latch     = 1'b0;
    w_evict_err = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_stream_ready) begin
          w_latch = 1'b1;
          if (skip) begin
            w_state_d = ST_READY;
          end else if (w_resident) begin
            w_state_d = ST_READY;
            // Row T lives in slot T[0]; it survives only while T >= last_row-1.
            w_evict_err = (({1'b0, row_to_wait} + 10'd1) < {1'b0, r_last_row});
          end else if (r_wr_row > w_req_need) begin
            w_state_d   = ST_READY;
            w_evict_err = 1'b1;
          end else begin
            w_state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (w_close && (r_wr_row == r_need)) begin
          w_state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (!in_stream_ready) begin
          w_state_d = ST_IDLE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (frame_start) begin
      w_state_d = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge CLOCK or negedge RESETN) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of block order.
    if (!RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Stream counters, request latch, handshake outputs and the fault flag
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_wr_col   <= '0;
      r_wr_row   <= '0;
      r_last_row <= '0;
      r_last_vld <= 1'b0;
      r_top_slot <= 1'b0;
      r_need     <= '0;
      r_tready   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else if (frame_start) begin
      r_wr_col   <= '0;
      r_wr_row   <= '0;
      r_last_row <= '0;
      r_last_vld <= 1'b0;
      r_tready   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_close) begin
        r_last_row <= r_wr_row;
        r_last_vld <= 1'b1;
        r_wr_row   <= r_wr_row + 9'd1;
        r_wr_col   <= '0;
      end else if (w_wr) begin
        r_wr_col   <= r_wr_col + 10'd1;
      end
      if (w_latch) begin
        r_top_slot <= row_to_wait[0];
        r_need     <= w_req_need;
      end
      // Ready follows the next state so it drops right after the closing beat.
      r_tready <= (w_state_d == ST_FILL);
      r_done   <= (r_state == ST_READY) && in_stream_ready;
      if (w_len_fault || w_eof_fault || w_evict_err) begin
        r_error <= 1'b1;
      end
    end
  end

  // Row slot storage
  always_ff @(posedge CLOCK) begin
    // NOTE: the pixel array carries no reset; stale contents are never served
    // as valid because buffer_done gates their use.
    if (w_wr) begin
      r_mem[r_wr_row[0]][r_wr_col[COL_AW-1:0]] <= S_AXIS_TDATA;
    end
  end

  // Registered neighbour read for the latched row pair
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_nb0 <= '0;
      r_nb1 <= '0;
      r_nb2 <= '0;
      r_nb3 <= '0;
    end else begin
      r_nb0 <= r_mem[r_top_slot][w_col_c[COL_AW-1:0]];
      r_nb1 <= r_mem[r_top_slot][w_col_n[COL_AW-1:0]];
      r_nb2 <= r_mem[r_need[0]][w_col_c[COL_AW-1:0]];
      r_nb3 <= r_mem[r_need[0]][w_col_n[COL_AW-1:0]];
    end
  end

  assign S_AXIS_TREADY = r_tready;
  assign buffer_done   = r_done;
  assign ERROR         = r_error;
  assign neighbor0     = r_nb0;
  assign neighbor1     = r_nb1;
  assign neighbor2     = r_nb2;
  assign neighbor3     = r_nb3;

endmodule

// File: tb/tb_rescale_line_buffer.sv
// Self-checking bench for rescale_line_buffer on a 4x4 source image.
module tb_rescale_line_buffer;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [8:0]  row_to_wait = '0;
  logic        skip = 1'b0;
  logic        in_stream_ready = 1'b0;
  logic        buffer_done;
  logic [10:0] nb_off = '0;
  logic [15:0] nb0, nb1, nb2, nb3;
  logic        error;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t       src_q[$];
  logic [63:0] exp_q[$];
  logic [15:0] img [H][W];

  int   total = 0;
  int   bad = 0;
  int   beats = 0;
  int   cyc = 0;
  int   sample_cyc = 0;
  int   last_acc_cyc = 0;
  int   req_cyc = 0;
  int   done_cyc = 0;
  logic done_s = 1'b0;

  always #5 clk = ~clk;

  rescale_line_buffer #(.SRC_W(W), .SRC_H(H), .PIX_W(16)) dut (
    .CLOCK          (clk),
    .RESETN         (rst_n),
    .frame_start    (frame_start),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TREADY  (s_tready),
    .S_AXIS_TLAST   (s_tlast),
    .row_to_wait    (row_to_wait),
    .skip           (skip),
    .in_stream_ready(in_stream_ready),
    .buffer_done    (buffer_done),
    .neighbor_offset(nb_off),
    .neighbor0      (nb0),
    .neighbor1      (nb1),
    .neighbor2      (nb2),
    .neighbor3      (nb3),
    .ERROR          (error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    if (src_q.size() > 0) begin
      s_tvalid = 1'b1;
      s_tdata  = src_q[0].data;
      s_tlast  = src_q[0].last;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
    end
  endtask

  // Sample on the falling edge, then advance past the rising edge and
  // retire the beat the source presented if it was accepted there.
  task automatic tick();
    logic acc;
    @(negedge clk);
    acc        = s_tvalid && s_tready;
    done_s     = buffer_done;
    sample_cyc = cyc;
    @(posedge clk);
    #1;
    if (acc) begin
      void'(src_q.pop_front());
      beats++;
      last_acc_cyc = sample_cyc;
    end
    cyc++;
    drive_src();
  endtask

  task automatic wait_done(input string tag);
    done_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done_s) begin
        done_cyc = sample_cyc;
        break;
      end
    end
    check({tag, "_done"}, 64'(done_s), 64'd1);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Queue one frame of pixels base+row*16+col; a short row 0 ends at col 2.
  task automatic load_frame(input logic [15:0] base, input bit short_row0);
    beat_t b;
    src_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (short_row0 && r == 0 && c == W - 1) continue;
        b.data = base + 16'(r * 16 + c);
        b.last = (short_row0 && r == 0) ? (c == W - 2) : (c == W - 1);
        img[r][c] = b.data;
        src_q.push_back(b);
      end
    end
    drive_src();
  endtask

  task automatic request(input int t, input logic sk);
    row_to_wait     = 9'(t);
    skip            = sk;
    in_stream_ready = 1'b1;
    req_cyc         = cyc;
  endtask

  task automatic release_req();
    in_stream_ready = 1'b0;
    skip            = 1'b0;
    repeat (3) tick();
  endtask

  // Expected window for top row t at column c, from the image model.
  task automatic query(input string tag, input int t, input int c);
    int          nr, cn;
    logic [63:0] exp, got;
    nr = (t + 1 > H - 1) ? H - 1 : t + 1;
    cn = (c + 1 > W - 1) ? W - 1 : c + 1;
    nb_off = 11'(c);
    exp_q.push_back({img[t][c], img[t][cn], img[nr][c], img[nr][cn]});
    tick();
    tick();
    got = {nb0, nb1, nb2, nb3};
    exp = exp_q.pop_front();
    check({tag, "_n0"}, 64'(got[63:48]), 64'(exp[63:48]));
    check({tag, "_n1"}, 64'(got[47:32]), 64'(exp[47:32]));
    check({tag, "_n2"}, 64'(got[31:16]), 64'(exp[31:16]));
    check({tag, "_n3"}, 64'(got[15:0]),  64'(exp[15:0]));
  endtask

  initial begin
    drive_src();
    tick();
    tick();
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_done",   64'(buffer_done), 64'd0);
    check("rst_nb",     {nb0, nb1, nb2, nb3}, 64'd0);
    check("rst_error",  64'(error), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic fill: T=0 needs rows 0 and 1, eight beats.
    pulse_frame_start();
    load_frame(16'h0000, 1'b0);
    beats = 0;
    request(0, 1'b0);
    wait_done("fill_t0");
    check("fill_t0_beats", 64'(beats), 64'd8);
    check("fill_t0_lat", 64'(done_cyc - last_acc_cyc), 64'd2);
    repeat (3) tick();
    check("fill_t0_hold", 64'(beats), 64'd8);
    query("fill_t0", 0, 1);

    // Window slide: T=1 fetches row 2 only; column 3 clamps.
    release_req();
    check("drop_done", 64'(buffer_done), 64'd0);
    beats = 0;
    request(1, 1'b0);
    wait_done("slide_t1");
    check("slide_t1_beats", 64'(beats), 64'd4);
    query("slide_t1", 1, 3);

    // Resident window with and without skip: no fetch, done two cycles on.
    release_req();
    beats = 0;
    request(1, 1'b1);
    wait_done("skip_t1");
    check("skip_t1_beats", 64'(beats), 64'd0);
    check("skip_t1_lat", 64'(done_cyc - req_cyc), 64'd2);
    release_req();
    request(1, 1'b0);
    wait_done("res_t1");
    check("res_t1_beats", 64'(beats), 64'd0);
    check("res_t1_lat", 64'(done_cyc - req_cyc), 64'd2);

    // Bottom edge: T=3 pairs row 3 with itself.
    release_req();
    beats = 0;
    request(3, 1'b0);
    wait_done("bot_t3");
    check("bot_t3_beats", 64'(beats), 64'd4);
    query("bot_t3", 3, 2);
    check("bot_error", 64'(error), 64'd0);

    // Short row 0: fault flagged, row 1 still starts at column 0.
    release_req();
    pulse_frame_start();
    load_frame(16'h0100, 1'b1);
    beats = 0;
    request(0, 1'b0);
    wait_done("short_t0");
    check("short_t0_beats", 64'(beats), 64'd7);
    check("short_error", 64'(error), 64'd1);
    query("short_t0", 0, 0);
    release_req();
    pulse_frame_start();
    check("fs_clear_error", 64'(error), 64'd0);

    // Eviction: rows 2-3 resident, then ask for T=0.
    load_frame(16'h0300, 1'b0);
    beats = 0;
    request(3, 1'b0);
    wait_done("full_t3");
    check("full_t3_beats", 64'(beats), 64'd16);
    check("full_error", 64'(error), 64'd0);
    release_req();
    request(0, 1'b0);
    wait_done("evict_t0");
    check("evict_error", 64'(error), 64'd1);
    release_req();
    pulse_frame_start();
    check("fs_clear_evict", 64'(error), 64'd0);

    // Asynchronous reset in the middle of a fill, then refill from row 0.
    load_frame(16'h0200, 1'b0);
    beats = 0;
    request(0, 1'b0);
    for (int i = 0; i < 30 && beats < 3; i++) tick();
    check("mid_fill_beats", 64'(beats), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tready", 64'(s_tready), 64'd0);
    check("arst_done",   64'(buffer_done), 64'd0);
    in_stream_ready = 1'b0;
    src_q.delete();
    drive_src();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load_frame(16'h0200, 1'b0);
    beats = 0;
    request(0, 1'b0);
    wait_done("refill_t0");
    check("refill_t0_beats", 64'(beats), 64'd8);
    query("refill_t0", 0, 0);
    release_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
